// File: rtl/dmux_dispatch_pkg.sv
// rtl/dmux_dispatch_pkg.sv - shared select codes, channel count, FSM states and round-robin helpers
package dmux_dispatch_pkg;

  localparam logic [1:0] SEL_IDLE = 2'b11;
  localparam int         NUM_CH   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

  // Returns {found, channel}; search starts at rr and wraps over the three channels.
  function automatic logic [2:0] rr_pick(input logic [1:0] rr, input logic [NUM_CH-1:0] ready);
    logic [1:0] c;
    logic [2:0] r;
    r = {1'b0, SEL_IDLE};
    c = rr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!r[2] && ready[c]) begin
        r = {1'b1, c};
      end
      c = next_ch(c);
    end
    return r;
  endfunction

endpackage

// File: rtl/dmux_dispatch_if.sv
// rtl/dmux_dispatch_if.sv - producer and demux-side signals of the dispatcher
interface dmux_dispatch_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ch_ready;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             busy;

  modport master (
    output in_data, in_valid, ch_ready,
    input  in_ready, sel, out_data, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, ch_ready,
    output in_ready, sel, out_data, out_valid, busy
  );
endinterface

// File: rtl/dmux_dispatch_fifo.sv
// rtl/dmux_dispatch_fifo.sv - synchronous FIFO with power-of-two depth and wrapping pointers
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rd_data = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are AW bits wide, so incrementing past DEPTH-1 wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dmux_dispatch.sv
// rtl/dmux_dispatch.sv - buffers producer words and dispatches each to one of three
// demux channels, round-robin among the channels that are ready.
module dmux_dispatch
  import dmux_dispatch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmux_dispatch_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t           state;
  logic [1:0]       rr;
  logic             ready_en;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [WIDTH-1:0] head;
  logic [2:0]       pick;
  logic             push;
  logic             dispatch;

  // ready_en keeps in_ready low until the first edge after reset release.
  assign bus.in_ready  = ready_en && !fifo_full;
  assign push          = bus.in_valid && bus.in_ready;
  assign pick          = rr_pick(rr, bus.ch_ready);
  assign dispatch      = (state == ST_ARB) && pick[2] && !fifo_empty;

  assign bus.sel       = sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = !fifo_empty || out_valid_q;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (bus.in_data),
    .pop     (dispatch),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr          <= 2'd0;
      ready_en    <= 1'b0;
      sel_q       <= SEL_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ready_en    <= 1'b1;
      out_valid_q <= dispatch;
      sel_q       <= dispatch ? pick[1:0] : SEL_IDLE;
      out_data_q  <= dispatch ? head : '0;
      if (dispatch) begin
        rr <= next_ch(pick[1:0]);
      end
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_ARB;
        end
        ST_ARB: begin
          if (fifo_empty) begin
            state <= ST_IDLE;
          end else if (!pick[2]) begin
            state <= ST_STALL;
          end else if (fifo_count == CW'(1) && !push) begin
            // Popping the last word with nothing arriving behind it.
            state <= ST_IDLE;
          end
        end
        ST_STALL: begin
          if (|bus.ch_ready) state <= ST_ARB;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmux_dispatch.sv
// tb/tb_dmux_dispatch.sv - directed self-checking bench for dmux_dispatch
module tb_dmux_dispatch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;

  logic [1:0]  got_sel[$];
  logic [15:0] got_data[$];
  int          got_cyc[$];

  dmux_dispatch_if #(.WIDTH(16)) bus ();

  dmux_dispatch #(
    .WIDTH (16),
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      got_sel.push_back(bus.sel);
      got_data.push_back(bus.out_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic clear_capture();
    got_sel.delete();
    got_data.delete();
    got_cyc.delete();
  endtask

  task automatic drive_word(input logic [15:0] w);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic apply_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.ch_ready = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_in_ready_low got=%b exp=0", bus.in_ready);
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rel_in_ready_before_edge got=%b exp=0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    clear_capture();
  endtask

  task automatic test_reset();
    apply_reset();
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (bus.sel !== 2'b11) begin
      mismatched++;
      $display("FAIL reset_sel got=%b exp=11", bus.sel);
    end
    compared++;
    if (bus.out_data !== 16'h0000) begin
      mismatched++;
      $display("FAIL reset_out_data got=%h exp=0000", bus.out_data);
    end
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    compared++;
    if (bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_round_robin();
    int p0;
    apply_reset();
    bus.ch_ready = 3'b111;
    drive_word(16'hA001);
    p0 = cyc;
    drive_word(16'hA002);
    drive_word(16'hA003);
    drive_word(16'hA004);
    repeat (6) @(posedge clk);
    #1;
    compared++;
    if (got_sel.size() != 4) begin
      mismatched++;
      $display("FAIL rr_count got=%0d exp=4", got_sel.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < got_sel.size()) begin
        compared++;
        if (got_sel[i] !== 2'(i % 3) || got_data[i] !== 16'hA001 + 16'(i)) begin
          mismatched++;
          $display("FAIL rr_word%0d got sel=%0d data=%h exp sel=%0d data=%h",
                   i, got_sel[i], got_data[i], i % 3, 16'hA001 + 16'(i));
        end
      end
    end
    if (got_cyc.size() == 4) begin
      compared++;
      if (got_cyc[0] - p0 != 2) begin
        mismatched++;
        $display("FAIL rr_latency got=%0d exp=2", got_cyc[0] - p0);
      end
      compared++;
      if (got_cyc[3] - got_cyc[0] != 3) begin
        mismatched++;
        $display("FAIL rr_throughput got=%0d exp=3", got_cyc[3] - got_cyc[0]);
      end
    end
  endtask

  task automatic test_full_stall();
    apply_reset();
    bus.ch_ready = 3'b000;
    for (int i = 0; i < 4; i++) drive_word(16'hB001 + 16'(i));
    compared++;
    if (bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL full_in_ready got=%b exp=0", bus.in_ready);
    end
    bus.in_data  = 16'hB005;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      mismatched++;
      $display("FAIL full_hold got in_ready=%b busy=%b exp in_ready=0 busy=1", bus.in_ready, bus.busy);
    end
    compared++;
    if (got_sel.size() != 0) begin
      mismatched++;
      $display("FAIL full_no_dispatch got=%0d exp=0", got_sel.size());
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.ch_ready = 3'b010;
    repeat (8) @(posedge clk);
    #1;
    compared++;
    if (got_sel.size() != 4) begin
      mismatched++;
      $display("FAIL full_drain_count got=%0d exp=4", got_sel.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < got_sel.size()) begin
        compared++;
        if (got_sel[i] !== 2'd1 || got_data[i] !== 16'hB001 + 16'(i)) begin
          mismatched++;
          $display("FAIL full_word%0d got sel=%0d data=%h exp sel=1 data=%h",
                   i, got_sel[i], got_data[i], 16'hB001 + 16'(i));
        end
      end
    end
    compared++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL full_end got busy=%b in_ready=%b exp busy=0 in_ready=1", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_rr_skip();
    apply_reset();
    bus.ch_ready = 3'b111;
    drive_word(16'hC001);
    repeat (4) @(posedge clk);
    #1;
    compared++;
    if (got_sel.size() != 1 || got_sel[0] !== 2'd0) begin
      mismatched++;
      $display("FAIL skip_prime got n=%0d exp n=1 sel=0", got_sel.size());
    end
    clear_capture();
    bus.ch_ready = 3'b101;
    drive_word(16'hC002);
    drive_word(16'hC003);
    repeat (5) @(posedge clk);
    #1;
    compared++;
    if (got_sel.size() != 2) begin
      mismatched++;
      $display("FAIL skip_count got=%0d exp=2", got_sel.size());
    end else begin
      compared++;
      if (got_sel[0] !== 2'd2 || got_data[0] !== 16'hC002) begin
        mismatched++;
        $display("FAIL skip_first got sel=%0d data=%h exp sel=2 data=c002", got_sel[0], got_data[0]);
      end
      compared++;
      if (got_sel[1] !== 2'd0 || got_data[1] !== 16'hC003) begin
        mismatched++;
        $display("FAIL skip_second got sel=%0d data=%h exp sel=0 data=c003", got_sel[1], got_data[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.ch_ready = 3'b000;
    for (int i = 0; i < 4; i++) drive_word(16'hE001 + 16'(i));
    bus.ch_ready = 3'b111;
    repeat (2) @(posedge clk);
    #2;
    compared++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hE001) begin
      mismatched++;
      $display("FAIL mid_pre got valid=%b data=%h exp valid=1 data=e001", bus.out_valid, bus.out_data);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (bus.out_valid !== 1'b0 || bus.sel !== 2'b11 || bus.out_data !== 16'h0000) begin
      mismatched++;
      $display("FAIL mid_outputs got valid=%b sel=%b data=%h exp 0/11/0000",
               bus.out_valid, bus.sel, bus.out_data);
    end
    compared++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_flags got in_ready=%b busy=%b exp 0/0", bus.in_ready, bus.busy);
    end
    clear_capture();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    compared++;
    if (got_sel.size() != 0 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_discard got dispatched=%0d busy=%b exp 0/0", got_sel.size(), bus.busy);
    end
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.ch_ready = 3'b000;
    drive_word(16'hD000);
    drive_word(16'hD001);
    repeat (2) @(posedge clk);
    #1;
    bus.ch_ready = 3'b111;
    @(posedge clk);
    #1;
    for (int i = 2; i < 12; i++) begin
      compared++;
      if (bus.in_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_in_ready%0d got=%b exp=1", i, bus.in_ready);
      end
      drive_word(16'hD000 + 16'(i));
    end
    repeat (6) @(posedge clk);
    #1;
    compared++;
    if (got_sel.size() != 12) begin
      mismatched++;
      $display("FAIL b2b_count got=%0d exp=12", got_sel.size());
    end
    for (int i = 0; i < 12; i++) begin
      if (i < got_sel.size()) begin
        compared++;
        if (got_sel[i] !== 2'(i % 3) || got_data[i] !== 16'hD000 + 16'(i)) begin
          mismatched++;
          $display("FAIL b2b_word%0d got sel=%0d data=%h exp sel=%0d data=%h",
                   i, got_sel[i], got_data[i], i % 3, 16'hD000 + 16'(i));
        end
      end
    end
    if (got_cyc.size() == 12) begin
      compared++;
      if (got_cyc[11] - got_cyc[0] != 11) begin
        mismatched++;
        $display("FAIL b2b_span got=%0d exp=11", got_cyc[11] - got_cyc[0]);
      end
    end
    compared++;
    if (bus.busy !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_busy_end got=%b exp=0", bus.busy);
    end
  endtask

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.ch_ready = 3'b000;
    test_reset();
    test_round_robin();
    test_full_stall();
    test_rr_skip();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
